imem_boot: RTL and testbench

Loadable instruction memory for the basic processor: a parametrised instruction RAM that replaces the fixed program ROM. After reset it clears itself, accepts a program over a valid/ready load port, then serves instruction fetches with a registered read until a reload is requested. It sits between the external program source (testbench or host) and the processor's instruction-fetch port.

---
 rtl/imem_pkg.sv | 19 +
 rtl/imem_boot_if.sv | 30 +++
 rtl/imem_boot_iram_core.sv | 22 ++
 rtl/imem_boot.sv | 136 +++++++++++++
 tb/tb_imem_boot.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_pkg.sv
// Shared types and width helpers for the loadable instruction memory.
package imem_pkg;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2
  } imem_state_t;

  localparam int WORD_W_DEF = 8;
  localparam int OP_W_DEF   = 3;
  localparam int ADDR_W     = WORD_W_DEF - OP_W_DEF;

  // Address bits left over once the opcode field is taken out of a word
  function automatic int addr_w(input int word_w, input int op_w);
    return word_w - op_w;
  endfunction

endpackage

// File: rtl/imem_boot_if.sv
// Load port and instruction-fetch port of imem_boot.
interface imem_boot_if
  import imem_pkg::*;
#(
  parameter int WORD_W = 8,
  parameter int OP_W   = 3
) ();
  localparam int AW = addr_w(WORD_W, OP_W);

  logic              ld_valid;
  logic              ld_ready;
  logic [WORD_W-1:0] ld_data;
  logic              ld_last;
  logic              reload;
  logic [AW-1:0]     Iaddress;
  logic [WORD_W-1:0] Idata;
  logic              Ivalid;
  logic              busy;
  logic [AW:0]       prog_len;

  modport master (
    output ld_valid, ld_data, ld_last, reload, Iaddress,
    input  ld_ready, Idata, Ivalid, busy, prog_len
  );

  modport slave (
    input  ld_valid, ld_data, ld_last, reload, Iaddress,
    output ld_ready, Idata, Ivalid, busy, prog_len
  );
endinterface

// File: rtl/imem_boot_iram_core.sv
// Single-port synchronous RAM with registered read data; storage is not reset.
module iram_core #(
  parameter int DEPTH  = 32,
  parameter int WORD_W = 8,
  parameter int AW     = 5
) (
  input  logic              clock,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);
  logic [WORD_W-1:0] mem_r [DEPTH];

  // Write port and registered read port share one address
  always_ff @(posedge clock) begin
    if (we) begin
      mem_r[addr] <= wdata;
    end
    rdata <= mem_r[addr];
  end
endmodule

// File: rtl/imem_boot.sv
// Loadable instruction RAM: self-clears after reset, accepts a program over a
// valid/ready port, then serves registered instruction fetches until reload.
module imem_boot
  import imem_pkg::*;
#(
  parameter int WORD_W = 8,
  parameter int OP_W   = 3,
  parameter int DEPTH  = 2 ** (WORD_W - OP_W)
) (
  input logic        clock,
  input logic        n_reset,
  imem_boot_if.slave bus
);
  localparam int AW = addr_w(WORD_W, OP_W);
  localparam logic [AW:0] LAST_C  = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_C   = (AW+1)'(1);
  localparam logic [AW:0] ZERO_C  = (AW+1)'(0);

  imem_state_t       state_r;
  logic [AW:0]       cnt_r;
  logic [AW:0]       ptr_r;
  logic [AW:0]       len_r;
  logic              ld_ready_r;
  logic              busy_r;
  logic              ivalid_r;
  logic              rd_en_r;
  logic              ld_hs_s;
  logic              in_range_s;
  logic              load_end_s;
  logic              ram_we_s;
  logic [AW-1:0]     ram_addr_s;
  logic [WORD_W-1:0] ram_wdata_s;
  logic [WORD_W-1:0] ram_rdata_s;

  assign ld_hs_s    = bus.ld_valid & ld_ready_r & (state_r == LOAD);
  assign in_range_s = ({1'b0, bus.Iaddress} < DEPTH_C);
  assign load_end_s = bus.ld_last | (ptr_r == LAST_C);

  // RAM port steering: clear counter, load pointer or fetch address by state
  always_comb begin
    ram_we_s    = 1'b0;
    ram_addr_s  = bus.Iaddress;
    ram_wdata_s = {WORD_W{1'b0}};
    case (state_r)
      CLEAR: begin
        ram_we_s   = 1'b1;
        ram_addr_s = cnt_r[AW-1:0];
      end
      LOAD: begin
        ram_we_s    = ld_hs_s;
        ram_addr_s  = ptr_r[AW-1:0];
        ram_wdata_s = bus.ld_data;
      end
      RUN:     ram_addr_s = bus.Iaddress;
      default: ram_we_s   = 1'b0;
    endcase
  end

  iram_core #(.DEPTH(DEPTH), .WORD_W(WORD_W), .AW(AW)) u_ram (
    .clock (clock),
    .we    (ram_we_s),
    .addr  (ram_addr_s),
    .wdata (ram_wdata_s),
    .rdata (ram_rdata_s)
  );

  // Sequencer: clear sweep, program load, fetch service, plus status registers
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      state_r    <= CLEAR;
      cnt_r      <= ZERO_C;
      ptr_r      <= ZERO_C;
      len_r      <= ZERO_C;
      ld_ready_r <= 1'b0;
      busy_r     <= 1'b1;
      ivalid_r   <= 1'b0;
      rd_en_r    <= 1'b0;
    end else begin
      case (state_r)
        CLEAR: begin
          ivalid_r <= 1'b0;
          rd_en_r  <= 1'b0;
          if (cnt_r == LAST_C) begin
            state_r    <= LOAD;
            cnt_r      <= ZERO_C;
            ptr_r      <= ZERO_C;
            len_r      <= ZERO_C;
            ld_ready_r <= 1'b1;
          end else begin
            cnt_r <= cnt_r + ONE_C;
          end
        end
        LOAD: begin
          if (ld_hs_s) begin
            ptr_r <= ptr_r + ONE_C;
            len_r <= len_r + ONE_C;
            // the word that fills the last slot ends the load even without ld_last
            if (load_end_s) begin
              state_r    <= RUN;
              ld_ready_r <= 1'b0;
              busy_r     <= 1'b0;
            end
          end
        end
        RUN: begin
          if (bus.reload) begin
            state_r  <= CLEAR;
            cnt_r    <= ZERO_C;
            busy_r   <= 1'b1;
            ivalid_r <= 1'b0;
            rd_en_r  <= 1'b0;
          end else begin
            ivalid_r <= 1'b1;
            rd_en_r  <= in_range_s;
          end
        end
        default: begin
          state_r    <= CLEAR;
          cnt_r      <= ZERO_C;
          ld_ready_r <= 1'b0;
          busy_r     <= 1'b1;
          ivalid_r   <= 1'b0;
          rd_en_r    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ld_ready = ld_ready_r;
  assign bus.busy     = busy_r;
  assign bus.Ivalid   = ivalid_r;
  assign bus.prog_len = len_r;
  // out-of-range or stale reads are forced to zero
  assign bus.Idata    = rd_en_r ? ram_rdata_s : {WORD_W{1'b0}};
endmodule

// File: tb/tb_imem_boot.sv
// Self-checking bench for imem_boot: default 32-word instance plus a 20-word one.
module tb_imem_boot;
  import imem_pkg::*;

  typedef struct {
    logic [4:0] addr;
    logic [7:0] exp;
  } vec_t;

  logic clock   = 1'b0;
  logic n_reset = 1'b0;
  int   n_pass  = 0;
  int   n_total = 0;

  logic [7:0] stim_q[$];
  logic [7:0] model_q[$];
  logic [7:0] q20[$];
  bit         model_done;
  vec_t       vecs [6];

  always #5 clock = ~clock;

  imem_boot_if #(.WORD_W(8), .OP_W(3)) bus ();
  imem_boot_if #(.WORD_W(8), .OP_W(3)) bus20 ();

  imem_boot dut (.clock(clock), .n_reset(n_reset), .bus(bus.slave));
  imem_boot #(.DEPTH(20)) dut20 (.clock(clock), .n_reset(n_reset), .bus(bus20.slave));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic idle_inputs();
    bus.ld_valid = 1'b0; bus.ld_data = 8'h00; bus.ld_last = 1'b0;
    bus.reload = 1'b0; bus.Iaddress = 5'd0;
  endtask

  task automatic model_reset();
    model_q.delete();
    model_done = 1'b0;
  endtask

  // Reference memory view: loaded prefix, zeros elsewhere
  function automatic logic [7:0] model_word(input int a);
    return (a < model_q.size()) ? model_q[a] : 8'h00;
  endfunction

  task automatic load_words(input bit use_last, input bit throttle);
    bit acc;
    bit last_acc;
    last_acc = 1'b0;
    for (int i = 0; i < stim_q.size(); i++) begin
      if (throttle) begin
        bus.ld_valid = 1'b0; bus.ld_data = 8'($urandom); bus.ld_last = 1'b0;
        @(negedge clock);
      end
      acc = !model_done && (model_q.size() < 32);
      check("ld_ready_word", 32'(bus.ld_ready), 32'(acc));
      bus.ld_valid = 1'b1;
      bus.ld_data  = stim_q[i];
      bus.ld_last  = use_last && (i == stim_q.size() - 1);
      if (acc) begin
        model_q.push_back(stim_q[i]);
        if (bus.ld_last || model_q.size() == 32) model_done = 1'b1;
        last_acc = (i == stim_q.size() - 1);
      end
      @(negedge clock);
    end
    idle_inputs();
    check("prog_len", 32'(bus.prog_len), 32'(model_q.size()));
    check("ld_ready_after_load", 32'(bus.ld_ready), 32'(!model_done));
    check("busy_after_load", 32'(bus.busy), 32'(!model_done));
    if (last_acc || !model_done) check("ivalid_first_run", 32'(bus.Ivalid), 32'd0);
  endtask

  task automatic fetch(input int a, input string name);
    logic [7:0] e;
    e = model_word(a);
    bus.Iaddress = 5'(a);
    @(negedge clock);
    check(name, 32'(bus.Idata), 32'(e));
    check("ivalid_run", 32'(bus.Ivalid), 32'd1);
  endtask

  task automatic do_reload(output int cycles);
    int old_len;
    old_len = model_q.size();
    bus.reload = 1'b1;
    @(negedge clock);
    bus.reload = 1'b0;
    check("reload_ivalid", 32'(bus.Ivalid), 32'd0);
    check("reload_idata", 32'(bus.Idata), 32'd0);
    check("reload_busy", 32'(bus.busy), 32'd1);
    check("reload_prog_len_held", 32'(bus.prog_len), 32'(old_len));
    cycles = 0;
    while (!bus.ld_ready && cycles < 100) begin
      @(negedge clock);
      cycles++;
    end
    check("prog_len_after_clear", 32'(bus.prog_len), 32'd0);
    model_reset();
  endtask

  initial begin
    int cyc;
    int bad_busy, bad_ready, bad_ivalid;
    int len;
    logic [7:0] w;

    vecs[0] = '{5'd0, 8'hDE}; vecs[1] = '{5'd1, 8'h3F}; vecs[2] = '{5'd2, 8'h1F};
    vecs[3] = '{5'd3, 8'hDE}; vecs[4] = '{5'd4, 8'h81}; vecs[5] = '{5'd5, 8'h00};
    idle_inputs();
    bus20.ld_valid = 1'b0; bus20.ld_data = 8'h00; bus20.ld_last = 1'b0;
    bus20.reload = 1'b0; bus20.Iaddress = 5'd0;
    model_reset();

    // Reset values, then the clear sweep
    repeat (2) @(negedge clock);
    check("rst_busy", 32'(bus.busy), 32'd1);
    check("rst_ld_ready", 32'(bus.ld_ready), 32'd0);
    check("rst_ivalid", 32'(bus.Ivalid), 32'd0);
    check("rst_idata", 32'(bus.Idata), 32'd0);
    check("rst_prog_len", 32'(bus.prog_len), 32'd0);
    n_reset = 1'b1;
    bad_busy = 0; bad_ready = 0; bad_ivalid = 0;
    for (int k = 1; k <= 32; k++) begin
      @(negedge clock);
      if (bus.busy !== 1'b1) bad_busy++;
      if (bus.Ivalid !== 1'b0) bad_ivalid++;
      if (k < 32 && bus.ld_ready !== 1'b0) bad_ready++;
    end
    check("clear_busy_high", 32'(bad_busy), 32'd0);
    check("clear_ready_low", 32'(bad_ready), 32'd0);
    check("clear_ivalid_low", 32'(bad_ivalid), 32'd0);
    check("ready_cycle33", 32'(bus.ld_ready), 32'd1);
    check("idle_prog_len", 32'(bus.prog_len), 32'd0);

    // Five-word program, table-driven readback
    stim_q = '{8'hDE, 8'h3F, 8'h1F, 8'hDE, 8'h81};
    load_words(1'b1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      bus.Iaddress = vecs[i].addr;
      @(negedge clock);
      check("table_idata", 32'(bus.Idata), 32'(vecs[i].exp));
      check("table_ivalid", 32'(bus.Ivalid), 32'd1);
    end

    // Reload, throttled 3-word load
    do_reload(cyc);
    check("reload_clear_cycles", 32'(cyc), 32'd32);
    stim_q = '{8'($urandom), 8'($urandom), 8'($urandom)};
    load_words(1'b1, 1'b1);
    for (int a = 0; a < 4; a++) fetch(a, "throttled_read");

    // One-word reload wipes older contents
    do_reload(cyc);
    stim_q = '{8'hA5};
    load_words(1'b1, 1'b0);
    for (int a = 0; a < 4; a++) fetch(a, "one_word_read");

    // Overflow: 33 words, no ld_last
    do_reload(cyc);
    stim_q.delete();
    for (int i = 0; i < 33; i++) stim_q.push_back(8'(8'h40 + i));
    load_words(1'b0, 1'b0);
    fetch(31, "overflow_mem31");
    fetch(0, "overflow_mem0");

    // Randomised programs against the reference model
    for (int r = 0; r < 4; r++) begin
      do_reload(cyc);
      check("rand_clear_cycles", 32'(cyc), 32'd32);
      len = $urandom_range(1, 32);
      stim_q.delete();
      for (int i = 0; i < len; i++) stim_q.push_back(8'($urandom));
      load_words((len < 32) ? 1'b1 : 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      for (int f = 0; f < 10; f++) fetch($urandom_range(0, 31), "rand_read");
    end

    // Reload ignored in LOAD, then reset pulse mid-load
    do_reload(cyc);
    stim_q = '{8'h11, 8'h22};
    load_words(1'b0, 1'b0);
    bus.reload = 1'b1;
    @(negedge clock);
    bus.reload = 1'b0;
    check("reload_in_load_ready", 32'(bus.ld_ready), 32'd1);
    check("reload_in_load_len", 32'(bus.prog_len), 32'd2);
    n_reset = 1'b0;
    #1;
    check("midload_rst_ready", 32'(bus.ld_ready), 32'd0);
    check("midload_rst_busy", 32'(bus.busy), 32'd1);
    check("midload_rst_len", 32'(bus.prog_len), 32'd0);
    check("midload_rst_ivalid", 32'(bus.Ivalid), 32'd0);
    check("midload_rst_idata", 32'(bus.Idata), 32'd0);
    @(negedge clock);
    n_reset = 1'b1;
    model_reset();
    cyc = 0;
    while (!bus.ld_ready && cyc < 100) begin
      @(negedge clock);
      cyc++;
    end
    check("rst_clear_cycles", 32'(cyc), 32'd32);
    stim_q = '{8'h77};
    load_words(1'b1, 1'b0);
    fetch(0, "after_rst_read0");
    fetch(1, "after_rst_recleared");

    // 20-word instance: overflow and out-of-range fetches
    cyc = 0;
    while (!bus20.ld_ready && cyc < 100) begin
      @(negedge clock);
      cyc++;
    end
    check("d20_ready", 32'(bus20.ld_ready), 32'd1);
    for (int i = 0; i < 21; i++) begin
      w = 8'($urandom);
      check("d20_ready_word", 32'(bus20.ld_ready), 32'(i < 20));
      bus20.ld_valid = 1'b1;
      bus20.ld_data  = w;
      if (i < 20) q20.push_back(w);
      @(negedge clock);
    end
    bus20.ld_valid = 1'b0;
    check("d20_prog_len", 32'(bus20.prog_len), 32'd20);
    check("d20_busy", 32'(bus20.busy), 32'd0);
    foreach (vecs[i]) begin
      int a;
      a = (i == 0) ? 25 : (i == 1) ? 19 : (i == 2) ? 0 : (i == 3) ? 20 : (i == 4) ? 31 : 7;
      bus20.Iaddress = 5'(a);
      @(negedge clock);
      check("d20_idata", 32'(bus20.Idata), 32'((a < 20) ? q20[a] : 8'h00));
      check("d20_ivalid", 32'(bus20.Ivalid), 32'd1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", n_pass, n_total);
    $fatal(1);
  end
endmodule
